hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Sequential hazard controller for the 5-stage RISC-V pipeline.
- Sits directly upstream of the PC stall stage: generates `pcEnable`/`pcRst` that the stall stage latches, plus the pipeline-register enables and flushes.
- Handles load-use bubbles, taken-branch redirects, data-memory wait freezes (with timeout) and a post-reset PC hold.

Parameters:
- REG_ADDR_W, 5, register-index width.
- RESET_HOLD_CYCLES, 2, cycles `pcRst` stays high after reset release (≥1).
- MEM_TIMEOUT, 64, max consecutive `memWait` cycles before `memTimeout` sets.
- WAIT_CNT_W, 7, wait-counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- idRs1  in  REG_ADDR_W  ID-stage source register 1.
- idRs2  in  REG_ADDR_W  ID-stage source register 2.
- idUsesRs1  in  1  ID instruction reads rs1.
- idUsesRs2  in  1  ID instruction reads rs2.
- exMemRead  in  1  EX instruction is a load.
- exRd  in  REG_ADDR_W  EX destination register.
- exBranchTaken  in  1  branch/jump resolved taken in EX.
- memWait  in  1  data memory not ready this cycle.
- pcEnable  out  1  PC update enable (to stall stage).
- pcRst  out  1  PC reset request (to stall stage).
- ifIdEnable  out  1  IF/ID register enable.
- ifIdFlush  out  1  IF/ID register clear.
- idExEnable  out  1  ID/EX register enable.
- idExFlush  out  1  ID/EX bubble insert.
- exMemEnable  out  1  EX/MEM enable.
- memTimeout  out  1  sticky memory-timeout error.
- stallCycles  out  16  perf counter (optional feature).
- flushCount  out  16  perf counter (optional feature).

Behaviour:
- Reset: `rst==0` at a posedge → state RST_HOLD, hold counter=0, wait counter=0, `memTimeout`=0, perf counters=0.
  - Outputs while `rst==0` or in RST_HOLD: `pcRst`=1, `pcEnable`=0, `ifIdFlush`=1, `idExFlush`=1, all other enables=0.
- States: RST_HOLD, RUN, LU_BUBBLE, MEM_FREEZE. Outputs are Mealy on state plus inputs, with no added latency.
- RST_HOLD: stays exactly RESET_HOLD_CYCLES cycles after `rst` goes high, then → RUN.
- Default in RUN (no hazard): `pcEnable`=1, all enables=1, flushes=0, `pcRst`=0.
- Load-use definition: `exMemRead` && `exRd`!=0 && ((`idUsesRs1` && `idRs1`==`exRd`) || (`idUsesRs2` && `idRs2`==`exRd`)).
  - Registers x0 never cause a hazard.
- Priority in RUN, highest first:
  1. `memWait`=1 → `pcEnable`, `ifIdEnable`, `idExEnable`, `exMemEnable` all 0; no flush; → MEM_FREEZE.
  2. `exBranchTaken`=1 → `ifIdFlush`=1, `idExFlush`=1, `pcEnable`=1 (redirect loads); stay RUN. A simultaneous load-use is ignored, since the ID instruction is squashed.
  3. Load-use → `pcEnable`=0, `ifIdEnable`=0, `idExFlush`=1 (one bubble); → LU_BUBBLE.
- LU_BUBBLE: exactly one cycle with RUN defaults (the EX stage now holds the bubble), then → RUN.
  - `memWait` in LU_BUBBLE takes priority → MEM_FREEZE.
- MEM_FREEZE: all enables 0 while `memWait`=1; wait counter increments and saturates.
  - When the counter reaches MEM_TIMEOUT, `memTimeout` sets and stays set until reset.
  - `memWait`=0 → clear counter, → RUN. Any pending `exBranchTaken` or load-use is evaluated in that same RUN cycle, because the EX contents were frozen.
- `rst` low mid-operation, in any state and including mid-freeze → RST_HOLD on the next posedge.
- Exactly one of the four states is active at all times; invalid encodings → RST_HOLD.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - `stallCycles` increments (saturating at 0xFFFF) on every cycle with `pcEnable`=0 outside RST_HOLD.
  - `flushCount` increments (saturating) on every taken-branch flush.
  - Both counters clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package hazard_pkg:
  - state enum (RST_HOLD, RUN, LU_BUBBLE, MEM_FREEZE);
  - REG_ZERO constant;
  - perf counter width 16.
- One sub-module, hazard_wait_timer: the saturating wait counter plus sticky `memTimeout`.
  - Inputs: clk, rst, count enable, clear.
  - Outputs: counter value, `memTimeout`.

Test Plan:
- Release reset with RESET_HOLD_CYCLES=2 → `pcRst`=1 for 2 cycles after `rst` rises, `pcEnable`=1 on cycle 3.
- `exMemRead`=1, `exRd`=5, `idRs2`=5, `idUsesRs2`=1 → one cycle of `pcEnable`=0, `ifIdEnable`=0, `idExFlush`=1; the same instruction in ID next cycle with no stall. Repeat with `exRd`=0 → no stall.
- Load-use plus `exBranchTaken` in the same cycle → `ifIdFlush`=`idExFlush`=1, `pcEnable`=1, state stays RUN.
- `memWait` high for 3 cycles during a load-use → all enables 0 for 3 cycles, then the load-use bubble is applied on the first RUN cycle.
- `memWait` held for 70 cycles with MEM_TIMEOUT=64 → `memTimeout` rises on wait cycle 64 and stays 1 after `memWait` drops until `rst`=0.
- With HAZARD_PERF_CNT_EN defined: 3 load-use stalls plus 2 branches → `stallCycles`=3, `flushCount`=2; without the macro, both read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    RST_HOLD   = 2'd0,
    RUN        = 2'd1,
    LU_BUBBLE  = 2'd2,
    MEM_FREEZE = 2'd3
  } hz_state_e;

  localparam int REG_ZERO = 0;
  localparam int PERF_W   = 16;
endpackage

// File: rtl/hazard_control_unit_wait_timer.sv
// Saturating count of consecutive data-memory wait cycles with a sticky
// timeout flag that only a reset clears.
module hazard_wait_timer #(
  parameter int WAIT_CNT_W  = 7,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnt_en,
  input  logic                  cnt_clr,
  output logic [WAIT_CNT_W-1:0] wait_cnt,
  output logic                  mem_timeout
);
  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  to_q, to_d;

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (cnt_en && cnt_q != LIMIT)
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    if (cnt_d == LIMIT)
      to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign wait_cnt    = cnt_q;
  assign mem_timeout = to_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freezes and post-reset PC hold. Perf counters under HAZARD_PERF_CNT_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int MEM_TIMEOUT       = 64,
  parameter int WAIT_CNT_W        = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exBranchTaken,
  input  logic                  memWait,
  output logic                  pcEnable,
  output logic                  pcRst,
  output logic                  ifIdEnable,
  output logic                  ifIdFlush,
  output logic                  idExEnable,
  output logic                  idExFlush,
  output logic                  exMemEnable,
  output logic                  memTimeout,
  output logic [PERF_W-1:0]     stallCycles,
  output logic [PERF_W-1:0]     flushCount
);
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              load_use, run_eval, freeze, rst_out, br_flush;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic              unused_wait;

  assign load_use = exMemRead && (exRd != REG_ADDR_W'(REG_ZERO)) &&
                    ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    run_eval    = 1'b0;
    freeze      = 1'b0;
    rst_out     = 1'b0;
    br_flush    = 1'b0;
    pcRst       = 1'b0;
    pcEnable    = 1'b1;
    ifIdEnable  = 1'b1;
    ifIdFlush   = 1'b0;
    idExEnable  = 1'b1;
    idExFlush   = 1'b0;
    exMemEnable = 1'b1;

    case (state_q)
      RST_HOLD: begin
        rst_out = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      RUN:        run_eval = 1'b1;
      LU_BUBBLE: begin
        if (memWait) begin
          freeze  = 1'b1;
          state_d = MEM_FREEZE;
        end else begin
          state_d = RUN;
        end
      end
      // The cycle memWait drops acts as a RUN cycle: EX was frozen, so its
      // pending branch/load-use must be resolved now, not one cycle later.
      MEM_FREEZE: run_eval = 1'b1;
      default: begin
        rst_out = 1'b1;
        state_d = RST_HOLD;
        hold_d  = '0;
      end
    endcase

    if (run_eval) begin
      if (memWait) begin
        freeze  = 1'b1;
        state_d = MEM_FREEZE;
      end else if (exBranchTaken) begin
        br_flush  = 1'b1;
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
        state_d   = RUN;
      end else if (load_use) begin
        pcEnable   = 1'b0;
        ifIdEnable = 1'b0;
        idExFlush  = 1'b1;
        state_d    = LU_BUBBLE;
      end else begin
        state_d = RUN;
      end
    end

    if (freeze) begin
      pcEnable    = 1'b0;
      ifIdEnable  = 1'b0;
      idExEnable  = 1'b0;
      exMemEnable = 1'b0;
    end

    if (!rst) begin
      rst_out  = 1'b1;
      freeze   = 1'b0;
      br_flush = 1'b0;
    end

    if (rst_out) begin
      pcRst       = 1'b1;
      pcEnable    = 1'b0;
      ifIdEnable  = 1'b0;
      ifIdFlush   = 1'b1;
      idExEnable  = 1'b0;
      idExFlush   = 1'b1;
      exMemEnable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_HOLD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  hazard_wait_timer #(
    .WAIT_CNT_W  (WAIT_CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .cnt_en      (freeze),
    .cnt_clr     (!freeze),
    .wait_cnt    (wait_cnt),
    .mem_timeout (memTimeout)
  );

  assign unused_wait = ^wait_cnt;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, stall_d, flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pcEnable && !rst_out && stall_q != '1)
      stall_d = stall_q + PERF_W'(1);
    if (br_flush && flush_q != '1)
      flush_d = flush_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stallCycles = stall_q;
  assign flushCount  = flush_q;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; inputs change on negedge, outputs checked 1ns later.
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] idRs1, idRs2, exRd;
  logic       idUsesRs1, idUsesRs2, exMemRead, exBranchTaken, memWait;
  logic       pcEnable, pcRst, ifIdEnable, ifIdFlush, idExEnable, idExFlush, exMemEnable;
  logic       memTimeout;
  logic [15:0] stallCycles, flushCount;

  int n_chk = 0;
  int n_fail = 0;

  // {pcRst, pcEnable, ifIdEnable, ifIdFlush, idExEnable, idExFlush, exMemEnable}
  localparam logic [6:0] C_RST = 7'b1001010;
  localparam logic [6:0] C_RUN = 7'b0110101;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_BR  = 7'b0111111;
  localparam logic [6:0] C_LU  = 7'b0000111;

  wire [6:0] ctl = {pcRst, pcEnable, ifIdEnable, ifIdFlush, idExEnable, idExFlush, exMemEnable};

  hazard_control_unit #(
    .REG_ADDR_W(5), .RESET_HOLD_CYCLES(2), .MEM_TIMEOUT(64), .WAIT_CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst), .idRs1(idRs1), .idRs2(idRs2),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .exMemRead(exMemRead), .exRd(exRd),
    .exBranchTaken(exBranchTaken), .memWait(memWait),
    .pcEnable(pcEnable), .pcRst(pcRst), .ifIdEnable(ifIdEnable), .ifIdFlush(ifIdFlush),
    .idExEnable(idExEnable), .idExFlush(idExFlush), .exMemEnable(exMemEnable),
    .memTimeout(memTimeout), .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2, input logic br, input logic mw);
    @(negedge clk);
    rst = r; exMemRead = mr; exRd = rd; idRs1 = r1; idRs2 = r2;
    idUsesRs1 = u1; idUsesRs2 = u2; exBranchTaken = br; memWait = mw;
    #1;
  endtask

  task automatic idle(input logic mw);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, mw);
  endtask

  initial begin
    rst = 1'b0; exMemRead = 1'b0; exRd = '0; idRs1 = '0; idRs2 = '0;
    idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; exBranchTaken = 1'b0; memWait = 1'b0;

    // Reset and PC hold release
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_ctl", 16'(ctl), 16'(C_RST));
    chk("rst_timeout", 16'(memTimeout), 16'd0);
    chk("rst_stall", stallCycles, 16'd0);
    chk("rst_flush", flushCount, 16'd0);
    idle(1'b0); chk("hold_c1", 16'(ctl), 16'(C_RST));
    idle(1'b0); chk("hold_c2", 16'(ctl), 16'(C_RST));
    idle(1'b0); chk("hold_c3_run", 16'(ctl), 16'(C_RUN));

    // Load-use on rs2, then bubble cycle, then free
    step(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_rs2", 16'(ctl), 16'(C_LU));
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_bubble", 16'(ctl), 16'(C_RUN));
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_x0", 16'(ctl), 16'(C_RUN));
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs1_unused", 16'(ctl), 16'(C_RUN));
    step(1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("no_load", 16'(ctl), 16'(C_RUN));
    step(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_rs1", 16'(ctl), 16'(C_LU));
    idle(1'b0); chk("lu_rs1_bubble", 16'(ctl), 16'(C_RUN));

    // Branch beats load-use and stays in RUN (next load-use stalls at once)
    step(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("br_over_lu", 16'(ctl), 16'(C_BR));
    step(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("br_then_run", 16'(ctl), 16'(C_LU));
    idle(1'b0);

    // memWait during a load-use: 3 frozen cycles, then the bubble
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("mw_freeze", 16'(ctl), 16'(C_FRZ));
    end
    step(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mw_then_lu", 16'(ctl), 16'(C_LU));
    step(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("mw_in_bubble", 16'(ctl), 16'(C_FRZ));
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mw_then_br", 16'(ctl), 16'(C_BR));

    // Timeout after 64 consecutive wait cycles, sticky afterwards
    for (int i = 1; i <= 70; i++) begin
      idle(1'b1);
      if (i == 1 || i == 70) chk("to_freeze", 16'(ctl), 16'(C_FRZ));
      if (i == 64) chk("to_before", 16'(memTimeout), 16'd0);
      if (i == 65) chk("to_set", 16'(memTimeout), 16'd1);
    end
    idle(1'b0);
    chk("to_release", 16'(ctl), 16'(C_RUN));
    chk("to_sticky", 16'(memTimeout), 16'd1);
    idle(1'b0);
    chk("to_sticky2", 16'(memTimeout), 16'd1);

    // Reset mid-freeze
    idle(1'b1); chk("pre_rst_frz", 16'(ctl), 16'(C_FRZ));
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_frz", 16'(ctl), 16'(C_RST));
    idle(1'b0);
    chk("rst_clr_to", 16'(memTimeout), 16'd0);
    chk("rst_hold_a", 16'(ctl), 16'(C_RST));
    idle(1'b0); chk("rst_hold_b", 16'(ctl), 16'(C_RST));
    idle(1'b0); chk("rst_run", 16'(ctl), 16'(C_RUN));

    // Perf counters: 3 load-use stalls + 2 branch flushes
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
    end
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", stallCycles, 16'd3);
    chk("perf_flush", flushCount, 16'd2);
`else
    chk("perf_stall_off", stallCycles, 16'd0);
    chk("perf_flush_off", flushCount, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
